// File: rtl/fxp_pkg.sv
// ---------------------------------------------------------------------------
// fxp_pkg
// Shared definitions for the fixed-point add/subtract/accumulate datapath.
//   fxp_op_e : operation code carried with each beat
//   fxp_max  : bit pattern of the most positive signed value of a given width
//   fxp_min  : bit pattern of the most negative signed value of a given width
// Both helpers return a 64-bit pattern; callers keep the low <width> bits.
// ---------------------------------------------------------------------------
package fxp_pkg;

   typedef enum logic [1:0] {
      FXP_ADD  = 2'd0,   // result = A + B
      FXP_SUB  = 2'd1,   // result = A - B
      FXP_ACC  = 2'd2,   // result = acc + A, acc <= result
      FXP_LOAD = 2'd3    // result = A,       acc <= result
   } fxp_op_e;

   // 0111...1 in the low <width> bits
   function automatic logic [63:0] fxp_max(input int unsigned width);
      fxp_max = (64'd1 << (width - 32'd1)) - 64'd1;
   endfunction

   // 1000...0 in the low <width> bits
   function automatic logic [63:0] fxp_min(input int unsigned width);
      fxp_min = 64'd1 << (width - 32'd1);
   endfunction

endpackage

// File: rtl/fxp_sat_add.sv
// ---------------------------------------------------------------------------
// fxp_sat_add
// Combinational signed add/subtract in WIDTH+1 bits with clamp or wrap back
// to WIDTH bits.
//   a, b      : WIDTH-bit signed operands
//   sub       : 1 = a - b, 0 = a + b
//   result    : WIDTH-bit saturated (SATURATE=1) or wrapped (SATURATE=0) sum
//   overflow  : sum does not fit in WIDTH bits (either direction)
// ---------------------------------------------------------------------------
module fxp_sat_add
   import fxp_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam logic [63:0]      MAX_PAT = fxp_max(WIDTH);
   localparam logic [63:0]      MIN_PAT = fxp_min(WIDTH);
   localparam logic [WIDTH-1:0] MAX_VAL = MAX_PAT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MIN_VAL = MIN_PAT[WIDTH-1:0];

   logic [WIDTH:0] a_ext_s;
   logic [WIDTH:0] b_ext_s;
   logic [WIDTH:0] sum_s;
   logic           ovf_pos_s;
   logic           ovf_neg_s;

   // Sign-extended add/subtract; one guard bit is enough for any pair of operands
   always_comb begin
      a_ext_s = {a[WIDTH-1], a};
      b_ext_s = {b[WIDTH-1], b};
      if (sub) begin
         sum_s = a_ext_s - b_ext_s;
      end else begin
         sum_s = a_ext_s + b_ext_s;
      end
   end

   // The value fits in WIDTH bits exactly when the guard bit equals the WIDTH sign bit;
   // a clear guard bit with a set sign bit means the true value is above the maximum
   assign ovf_pos_s = ~sum_s[WIDTH] &  sum_s[WIDTH-1];
   assign ovf_neg_s =  sum_s[WIDTH] & ~sum_s[WIDTH-1];
   assign overflow  = ovf_pos_s | ovf_neg_s;

   // Clamp to the format limits, or keep the low bits when wrapping
   always_comb begin
      if (SATURATE && ovf_pos_s) begin
         result = MAX_VAL;
      end else if (SATURATE && ovf_neg_s) begin
         result = MIN_VAL;
      end else begin
         result = sum_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fixed_point_addsub_pipe
// Two-stage streaming fixed-point add/subtract/accumulate unit with
// valid/ready flow control, saturating or wrapping arithmetic and
// per-result plus sticky overflow reporting.
//   i_clk, i_rst          : clock (rising edge), async active-high reset
//   i_valid / o_ready     : input beat handshake
//   i_op                  : fxp_op_e operation code
//   i_operandA/B          : signed Q-format operands (B unused by ACC/LOAD)
//   o_valid / i_ready     : output result handshake
//   o_val, o_overflow     : registered result and its overflow flag
//   o_overflow_sticky     : set by any overflowing result until i_clr_sticky
// FBITS only documents the binary-point position; the arithmetic is the
// same for every Q format sharing WIDTH.
// ---------------------------------------------------------------------------
module fixed_point_addsub_pipe
   import fxp_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int FBITS    = 8,
   parameter bit SATURATE = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_operandA,
   input  logic [WIDTH-1:0] i_operandB,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_val,
   output logic             o_overflow,
   output logic             o_overflow_sticky,
   input  logic             i_clr_sticky
);

   generate
      if (WIDTH < 4 || WIDTH > 64 || FBITS < 0 || FBITS >= WIDTH) begin : g_bad_params
         $error("fixed_point_addsub_pipe: illegal WIDTH/FBITS combination");
      end
   endgenerate

   // Stage 1 holding registers
   logic             s1_valid_r;
   fxp_op_e          s1_op_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;

   // Running accumulator for ACC/LOAD
   logic [WIDTH-1:0] acc_r;

   // Handshake / datapath signals
   logic             s2_adv_s;
   logic             s1_adv_s;
   logic [WIDTH-1:0] add_a_s;
   logic [WIDTH-1:0] add_b_s;
   logic             add_sub_s;
   logic             acc_upd_s;
   logic [WIDTH-1:0] res_s;
   logic             ovf_s;

   // S2 may load whenever it is empty or its result is leaving this cycle.
   // o_ready depends combinationally on i_ready so a full pipe keeps streaming.
   assign s2_adv_s = ~o_valid | i_ready;
   assign s1_adv_s = s1_valid_r & s2_adv_s;
   assign o_ready  = ~s1_valid_r | s2_adv_s;

   // Operand routing into the shared adder; acc is read straight from its register,
   // so a back-to-back ACC sees the value written by the beat just ahead of it
   always_comb begin
      add_a_s   = s1_a_r;
      add_b_s   = s1_b_r;
      add_sub_s = 1'b0;
      acc_upd_s = 1'b0;
      case (s1_op_r)
         FXP_ADD: begin
            add_a_s   = s1_a_r;
            add_b_s   = s1_b_r;
            add_sub_s = 1'b0;
            acc_upd_s = 1'b0;
         end
         FXP_SUB: begin
            add_a_s   = s1_a_r;
            add_b_s   = s1_b_r;
            add_sub_s = 1'b1;
            acc_upd_s = 1'b0;
         end
         FXP_ACC: begin
            add_a_s   = acc_r;
            add_b_s   = s1_a_r;
            add_sub_s = 1'b0;
            acc_upd_s = 1'b1;
         end
         FXP_LOAD: begin
            // A + 0 can never overflow, so LOAD passes A through unchanged
            add_a_s   = s1_a_r;
            add_b_s   = {WIDTH{1'b0}};
            add_sub_s = 1'b0;
            acc_upd_s = 1'b1;
         end
         default: begin
            add_a_s   = s1_a_r;
            add_b_s   = s1_b_r;
            add_sub_s = 1'b0;
            acc_upd_s = 1'b0;
         end
      endcase
   end

   fxp_sat_add #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_sat_add (
      .a        (add_a_s),
      .b        (add_b_s),
      .sub      (add_sub_s),
      .result   (res_s),
      .overflow (ovf_s)
   );

   // Stage 1 capture: refills whenever the stage is empty or draining into S2
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= FXP_ADD;
         s1_a_r     <= {WIDTH{1'b0}};
         s1_b_r     <= {WIDTH{1'b0}};
      end else if (o_ready) begin
         s1_valid_r <= i_valid;
         if (i_valid) begin
            s1_op_r <= fxp_op_e'(i_op);
            s1_a_r  <= i_operandA;
            s1_b_r  <= i_operandB;
         end
      end
   end

   // Stage 2 output registers: hold while the downstream stalls
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid    <= 1'b0;
         o_val      <= {WIDTH{1'b0}};
         o_overflow <= 1'b0;
      end else if (s2_adv_s) begin
         o_valid <= s1_valid_r;
         if (s1_valid_r) begin
            o_val      <= res_s;
            o_overflow <= ovf_s;
         end
      end
   end

   // Accumulator: written only as an ACC/LOAD beat moves into S2
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_r <= {WIDTH{1'b0}};
      end else if (s1_adv_s && acc_upd_s) begin
         acc_r <= res_s;
      end
   end

   // Sticky overflow: a new overflow outranks a clear in the same cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overflow_sticky <= 1'b0;
      end else if (s1_adv_s && ovf_s) begin
         o_overflow_sticky <= 1'b1;
      end else if (i_clr_sticky) begin
         o_overflow_sticky <= 1'b0;
      end
   end

endmodule

// File: doc/fixed_point_addsub_pipe.md
# fixed_point_addsub_pipe

Parametrised, pipelined fixed-point add/subtract/accumulate unit with per-result and sticky overflow reporting, saturating or wrapping arithmetic, and valid/ready flow control on both sides. It is the streaming successor to the single-cycle saturating adder. It sits between sample sources and downstream DSP stages (FIR taps, gain stages) in the filter datapath. Operands and result share one signed Q format.

## Interface
- WIDTH, 16: total bits per operand/result, signed two's complement, ≥ 4
- FBITS, 8: fractional bits within WIDTH; format only, no arithmetic effect; 0 ≤ FBITS < WIDTH
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap (low WIDTH bits kept)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input beat present
- o_ready  out  1  unit accepts a beat this cycle
- i_op  in  2  0 ADD (A+B), 1 SUB (A−B), 2 ACC (acc+A), 3 LOAD (acc=A; result=A)
- i_operandA  in  WIDTH  signed operand A
- i_operandB  in  WIDTH  signed operand B; ignored for ACC/LOAD
- o_valid  out  1  result present
- i_ready  in  1  downstream accepts result
- o_val  out  WIDTH  signed result
- o_overflow  out  1  this result overflowed (either direction); qualified by o_valid
- o_overflow_sticky  out  1  set by any overflowing result, held until cleared
- i_clr_sticky  in  1  clears o_overflow_sticky

## Operation
- Input accept: i_valid && o_ready. Output fire: o_valid && i_ready.
- Stage 1 (S1): registers op, A, B and s1_valid on accept.
- Stage 2 (S2): computes in WIDTH+1 bits, sign-extended: ADD A+B, SUB A−B, ACC acc+A, LOAD A. Registers o_val, o_overflow, o_valid.
- Overflow: ext > 2^(WIDTH−1)−1 → positive; ext < −2^(WIDTH−1) → negative. Both set o_overflow.
- SATURATE=1: positive → 0x7F..F; negative → 0x80..0. SATURATE=0: ext[WIDTH−1:0].
- Accumulator: WIDTH-bit register acc, updated when an ACC/LOAD beat moves S1→S2. New value = the (saturated/wrapped) result. ADD/SUB leave acc unchanged.
- Back-to-back ACC beats each see the acc written by the previous beat. No bubbles required.
- Sticky: set on the cycle an overflowing result is registered into S2. i_clr_sticky clears it. Simultaneous set and clear → set wins.

## Timing
- Reset values: o_valid 0, o_val 0, o_overflow 0, o_overflow_sticky 0, acc 0, s1_valid 0. o_ready = 1 after reset release.
- Latency: accepted beat appears on o_valid exactly 2 cycles later when unstalled.
- Throughput: 1 beat/cycle with i_ready held high.
- s2_adv = !o_valid || i_ready. s1_adv = s1_valid && s2_adv. o_ready = !s1_valid || s2_adv (combinational from i_ready).
- Stall: while o_valid && !i_ready, o_val/o_overflow/o_valid and the S1 contents hold. acc does not update.
- No beat is dropped or duplicated under any i_valid/i_ready pattern.
- Reset asserted mid-operation: all in-flight beats are discarded, acc is cleared, and all outputs take reset values immediately (async).

## Structure
- Shared package fxp_pkg holds: op enum (FXP_ADD, FXP_SUB, FXP_ACC, FXP_LOAD), and functions fxp_max(WIDTH)/fxp_min(WIDTH) for the saturation constants.
- One sub-module, fxp_sat_add: combinational WIDTH+1 add/sub plus clamp/wrap, with an overflow output. It is instanced once in S2.
- Remaining RTL: pipeline registers, handshake logic, acc, sticky flag.

## Test plan
- WIDTH=8, FBITS=4, SATURATE=1: ADD 0x70+0x20 → o_val 0x7F, o_overflow 1, sticky 1; ADD 0x10+0x20 → 0x30, o_overflow 0, sticky stays 1.
- Negative limits: ADD 0x80+0xFF → 0x80, o_overflow 1. SUB 0x00−0x80 → 0x7F, o_overflow 1. SUB 0x10−0x30 → 0xE0, o_overflow 0.
- Accumulate: LOAD 0x10, then 3× ACC 0x10 back-to-back with no gaps → results 0x10, 0x20, 0x30, 0x40. Then 4× ACC 0x20 → last two results 0x7F, o_overflow 1.
- SATURATE=0: ADD 0x70+0x20 → 0x90, o_overflow 1.
- Backpressure: stream 8 random beats with i_ready toggling pseudo-randomly → outputs match the model in order, none lost or duplicated. o_val stays stable while stalled. With i_ready low and both stages full, o_ready is 0.
- Async reset: assert i_rst with both stages full and acc=0x40 → o_valid 0 before the next edge, sticky 0. Next ACC 0x10 after release → 0x10.
